// File: rtl/cache_pkg.sv
// Shared cache geometry and refill FSM encoding used by the miss-handling path.
package cache_pkg;
  localparam int ADDR_W         = 32;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
  localparam int CNT_W          = 16;
  localparam int OFFSET_LSB     = 2;
  localparam int INDEX_LSB      = 4;
  localparam int TAG_LSB        = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } refill_state_e;
endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Pipeline request, memory read port and cache fill signals of the refill controller.
interface cache_refill_ctrl_if #(
  parameter int ADDR_W         = cache_pkg::ADDR_W,
  parameter int WORD_W         = cache_pkg::WORD_W,
  parameter int WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE,
  parameter int CNT_W          = cache_pkg::CNT_W
);
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              hit;
  logic              stall;
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;
  logic [LINE_W-1:0] data_line;
  logic [ADDR_W-1:0] fill_addr;
  logic              line_valid;
  logic [CNT_W-1:0]  refill_count;

  modport master (
    output req_valid, req_addr, hit, mem_ack, mem_rdata,
    input  stall, mem_rd_req, mem_addr, data_line, fill_addr, line_valid, refill_count
  );

  modport slave (
    input  req_valid, req_addr, hit, mem_ack, mem_rdata,
    output stall, mem_rd_req, mem_addr, data_line, fill_addr, line_valid, refill_count
  );
endinterface

// File: rtl/cache_refill_ctrl_line_assembler.sv
// Word index counter plus line register; each acked word is inserted at the current index.
module line_assembler #(
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  localparam int IDX_W         = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clr,
  input  logic                                   wr,
  input  logic [WORD_W-1:0]                      wdata,
  output logic [WORDS_PER_LINE-1:0][WORD_W-1:0]  line,
  output logic                                   last
);
  logic [IDX_W-1:0] idx;

  assign last = (idx == IDX_W'(WORDS_PER_LINE - 1));

  // Old words stay in place until overwritten so the last line remains readable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      line <= '0;
    end else begin
      if (wr) begin
        line[idx] <= wdata;
        idx       <= idx + 1'b1;
      end
      if (clr) idx <= '0;
    end
  end
endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss handler: stalls the pipeline, fetches the missing line word by word, strobes it out.
module cache_refill_ctrl #(
  parameter int ADDR_W         = cache_pkg::ADDR_W,
  parameter int WORD_W         = cache_pkg::WORD_W,
  parameter int WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE,
  parameter int CNT_W          = cache_pkg::CNT_W
) (
  input logic                clk,
  input logic                rst,
  cache_refill_ctrl_if.slave bus
);
  import cache_pkg::*;

  localparam int WORD_BYTES = WORD_W / 8;
  localparam int LINE_LSB   = $clog2(WORDS_PER_LINE * WORD_BYTES);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << LINE_LSB) - 64'd1);

  refill_state_e                        state;
  logic                                 miss, clr, wr, last;
  logic                                 mem_rd_req_q, line_valid_q;
  logic [ADDR_W-1:0]                    mem_addr_q, fill_addr_q;
  logic [CNT_W-1:0]                     cnt_q;
  logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line;

  assign miss = bus.req_valid & ~bus.hit;
  assign clr  = (state == IDLE) & miss;
  assign wr   = (state == FETCH) & bus.mem_ack;

  // The first miss cycle must already be stalled, so stall cannot wait for the FSM.
  assign bus.stall        = (state != IDLE) | miss;
  assign bus.mem_rd_req   = mem_rd_req_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.fill_addr    = fill_addr_q;
  assign bus.line_valid   = line_valid_q;
  assign bus.refill_count = cnt_q;
  assign bus.data_line    = line;

  line_assembler #(
    .WORD_W         (WORD_W),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_asm (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .wr    (wr),
    .wdata (bus.mem_rdata),
    .line  (line),
    .last  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mem_rd_req_q <= 1'b0;
      mem_addr_q   <= '0;
      fill_addr_q  <= '0;
      line_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      line_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (miss) begin
            fill_addr_q  <= bus.req_addr & LINE_MASK;
            mem_addr_q   <= bus.req_addr & LINE_MASK;
            mem_rd_req_q <= 1'b1;
            state        <= FETCH;
          end
        end
        FETCH: begin
          if (bus.mem_ack) begin
            if (last) begin
              mem_rd_req_q <= 1'b0;
              line_valid_q <= 1'b1;
              state        <= DONE;
            end else begin
              mem_addr_q <= mem_addr_q + ADDR_W'(WORD_BYTES);
            end
          end
        end
        DONE: begin
          cnt_q <= cnt_q + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
